// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage pipelined arithmetic/logic/shift unit with
// valid-qualified I/O, an illegal-operation flag and a blinking LED error indicator.
module alsu_pipe #(
    parameter int unsigned WIDTH          = 3,
    parameter string       INPUT_PRIORITY = "A",
    parameter string       FULL_ADDER     = "ON",
    parameter int unsigned LED_WIDTH      = 16,
    parameter int unsigned BLINK_DIV      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic [2:0]             opcode,
    input  logic                   cin,
    input  logic                   serial_in,
    input  logic                   direction,
    input  logic                   red_op_A,
    input  logic                   red_op_B,
    input  logic                   bypass_A,
    input  logic                   bypass_B,
    output logic [2*WIDTH-1:0]     out,
    output logic                   out_valid,
    output logic                   invalid,
    output logic [LED_WIDTH-1:0]   leds
);

    localparam int unsigned OW = 2 * WIDTH;
    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic PRIO_A = (INPUT_PRIORITY == "A");
    localparam logic CIN_EN = (FULL_ADDER == "ON");

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MULT   = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5,
        OP_ILL6   = 3'd6,
        OP_ILL7   = 3'd7
    } opcode_e;

    // stage-1 input registers
    logic [WIDTH-1:0] a_q, b_q;
    opcode_e          op_q;
    logic             cin_q, sin_q, dir_q;
    logic             red_a_q, red_b_q, byp_a_q, byp_b_q;
    logic             v1_q;

    // stage-2 combinational result
    logic [OW-1:0]    ext_a, ext_b;
    logic [OW-1:0]    result;
    logic             illegal;
    logic             pick_a_byp, pick_a_red;
    logic [WIDTH-1:0] red_src;

    // blink state
    logic [CW-1:0]    blink_cnt;
    logic             blink_wrap;

    assign ext_a      = {{WIDTH{1'b0}}, a_q};
    assign ext_b      = {{WIDTH{1'b0}}, b_q};
    assign blink_wrap = (blink_cnt == CNT_LAST);

    // Stage 1: capture operands and controls when in_valid is high
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            cin_q   <= 1'b0;
            sin_q   <= 1'b0;
            dir_q   <= 1'b0;
            red_a_q <= 1'b0;
            red_b_q <= 1'b0;
            byp_a_q <= 1'b0;
            byp_b_q <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                a_q     <= A;
                b_q     <= B;
                op_q    <= opcode_e'(opcode);
                cin_q   <= cin;
                sin_q   <= serial_in;
                dir_q   <= direction;
                red_a_q <= red_op_A;
                red_b_q <= red_op_B;
                byp_a_q <= bypass_A;
                byp_b_q <= bypass_B;
            end
        end
    end

    // Stage 2: compute the next out value from the captured transaction
    always_comb begin
        illegal    = (op_q == OP_ILL6) || (op_q == OP_ILL7) ||
                     ((red_a_q || red_b_q) && (op_q != OP_AND) && (op_q != OP_XOR));
        pick_a_byp = byp_a_q && (!byp_b_q || PRIO_A);
        pick_a_red = red_a_q && (!red_b_q || PRIO_A);
        red_src    = pick_a_red ? a_q : b_q;
        result     = out;
        if (illegal) begin
            result = '0;
        end else if (byp_a_q || byp_b_q) begin
            result = pick_a_byp ? ext_a : ext_b;
        end else begin
            case (op_q)
                OP_AND: begin
                    if (red_a_q || red_b_q) result = {{(OW-1){1'b0}}, &red_src};
                    else                    result = ext_a & ext_b;
                end
                OP_XOR: begin
                    if (red_a_q || red_b_q) result = {{(OW-1){1'b0}}, ^red_src};
                    else                    result = ext_a ^ ext_b;
                end
                OP_ADD:    result = ext_a + ext_b + {{(OW-1){1'b0}}, cin_q & CIN_EN};
                OP_MULT:   result = ext_a * ext_b;
                OP_SHIFT:  result = dir_q ? {out[OW-2:0], sin_q} : {sin_q, out[OW-1:1]};
                OP_ROTATE: result = dir_q ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
                default:   result = '0;
            endcase
        end
    end

    // Output registers and LED blink engine
    always_ff @(posedge clk) begin
        if (!rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            invalid   <= 1'b0;
            leds      <= '0;
            blink_cnt <= '0;
        end else begin
            out_valid <= v1_q;
            if (v1_q) begin
                out     <= result;
                invalid <= illegal;
            end
            // an illegal transaction and idle cycles in error both advance the blink
            if ((v1_q && illegal) || (!v1_q && invalid)) begin
                if (blink_wrap) begin
                    leds      <= ~leds;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else if (v1_q) begin
                leds      <= '0;
                blink_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alsu_pipe.sv
// tb_alsu_pipe: directed + random checks of two alsu_pipe configurations
// against a behavioural model, plus hand-computed literal expectations.
module tb_alsu_pipe;

    localparam int unsigned W   = 3;
    localparam int unsigned OW  = 2 * W;
    localparam int unsigned MAXA = (1 << W) - 1;
    localparam int unsigned MOD  = 1 << OW;

    logic clk = 1'b0;
    logic rst, in_valid;
    logic [W-1:0] A, B;
    logic [2:0] opcode;
    logic cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;

    logic [OW-1:0] out_d [2];
    logic          ov_d  [2];
    logic          inv_d [2];
    logic [15:0]   leds_d [2];

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    // instance 0: defaults (priority A, full adder on, blink every edge)
    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_WIDTH(16), .BLINK_DIV(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .out(out_d[0]), .out_valid(ov_d[0]), .invalid(inv_d[0]), .leds(leds_d[0]));

    // instance 1: priority B, carry-in ignored, blink every 3 edges
    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .LED_WIDTH(16), .BLINK_DIV(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .cin(cin), .serial_in(serial_in), .direction(direction),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .out(out_d[1]), .out_valid(ov_d[1]), .invalid(inv_d[1]), .leds(leds_d[1]));

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned a, b, op;
        bit cin, sin, dir, ra, rb, ba, bb;
    } tx_t;

    tx_t         m_tx;
    bit          m_v1 = 1'b0;
    int unsigned m_out [2] = '{0, 0};
    bit          m_inv [2] = '{0, 0};
    bit          m_ov  [2] = '{0, 0};
    int unsigned m_steps [2] = '{0, 0};

    function automatic int unsigned blink_div(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void calc(input tx_t t, input int unsigned cur, input bit prio_a, input bit fa,
                                 output bit ill, output int unsigned res);
        int unsigned v;
        ill = (t.op >= 6) || ((t.ra || t.rb) && t.op >= 2);
        res = cur;
        if (ill) res = 0;
        else if (t.ba || t.bb) res = (t.ba && (!t.bb || prio_a)) ? t.a : t.b;
        else begin
            case (t.op)
                0, 1: begin
                    if (t.ra || t.rb) begin
                        v = (t.ra && (!t.rb || prio_a)) ? t.a : t.b;
                        if (t.op == 0) res = (v == MAXA) ? 1 : 0;
                        else           res = $countones(v) % 2;
                    end else begin
                        res = (t.op == 0) ? (t.a & t.b) : (t.a ^ t.b);
                    end
                end
                2: res = t.a + t.b + ((fa && t.cin) ? 1 : 0);
                3: res = t.a * t.b;
                4: res = t.dir ? ((cur * 2 + t.sin) % MOD) : (cur / 2 + t.sin * (MOD / 2));
                5: res = t.dir ? ((cur * 2) % MOD + cur / (MOD / 2)) : (cur / 2 + (cur % 2) * (MOD / 2));
                default: res = 0;
            endcase
        end
    endfunction

    always @(posedge clk) begin
        bit ill;
        int unsigned res;
        if (!rst) begin
            m_v1 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_out[i] = 0; m_inv[i] = 0; m_ov[i] = 0; m_steps[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_v1) begin
                    calc(m_tx, m_out[i], i == 0, i == 0, ill, res);
                    m_out[i] = res;
                    m_inv[i] = ill;
                    m_ov[i]  = 1'b1;
                    m_steps[i] = ill ? m_steps[i] + 1 : 0;
                end else begin
                    m_ov[i] = 1'b0;
                    if (m_inv[i]) m_steps[i] = m_steps[i] + 1;
                end
            end
            m_v1 = in_valid;
            if (in_valid) begin
                m_tx.a = A; m_tx.b = B; m_tx.op = opcode;
                m_tx.cin = cin; m_tx.sin = serial_in; m_tx.dir = direction;
                m_tx.ra = red_op_A; m_tx.rb = red_op_B; m_tx.ba = bypass_A; m_tx.bb = bypass_B;
            end
        end
    end

    // compare DUT against model shortly after every active edge
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_out%0d", i), out_d[i], m_out[i]);
                chk($sformatf("model_valid%0d", i), ov_d[i], m_ov[i]);
                chk($sformatf("model_invalid%0d", i), inv_d[i], m_inv[i]);
                chk($sformatf("model_leds%0d", i), leds_d[i],
                    ((m_steps[i] / blink_div(i)) % 2 == 1) ? 16'hFFFF : 16'h0000);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int unsigned a, b, op, input bit c, s, d, ra, rb, ba, bb);
        A = a[W-1:0]; B = b[W-1:0]; opcode = op[2:0];
        cin = c; serial_in = s; direction = d;
        red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
    endtask

    // drive one transaction, then idle; returns at the negedge where its result is visible
    task automatic txn(input int unsigned a, b, op, input bit c, s, d, ra, rb, ba, bb);
        @(negedge clk);
        drive(a, b, op, c, s, d, ra, rb, ba, bb);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_res(input string name, input int unsigned e0, e1);
        chk({name, "_out0"}, out_d[0], e0);
        chk({name, "_out1"}, out_d[1], e1);
        chk({name, "_valid0"}, ov_d[0], 1);
        chk({name, "_valid1"}, ov_d[1], 1);
    endtask

    logic [15:0] exp_l0 [5] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    logic [15:0] exp_l1 [5] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};

    initial begin
        // reset with random inputs and in_valid asserted
        rst = 1'b0;
        in_valid = 1'b1;
        drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_out", out_d[i], 0);
            chk("reset_valid", ov_d[i], 0);
            chk("reset_invalid", inv_d[i], 0);
            chk("reset_leds", leds_d[i], 16'h0000);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_out0", out_d[0], 0);
        chk("idle_valid0", ov_d[0], 0);

        // bypass with both selects, opcode ignored
        txn(5, 2, 3, 0, 0, 0, 0, 0, 1, 1);
        expect_res("bypass", 5, 2);
        chk("bypass_leds0", leds_d[0], 16'h0000);

        // reductions
        txn(7, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        expect_res("redand_a7", 1, 1);
        txn(6, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        expect_res("redand_a6", 0, 0);
        txn(0, 6, 1, 0, 0, 0, 0, 1, 0, 0);
        expect_res("redxor_b6", 0, 0);
        txn(0, 7, 1, 0, 0, 0, 0, 1, 0, 0);
        expect_res("redxor_b7", 1, 1);
        txn(7, 6, 1, 0, 0, 0, 1, 1, 0, 0);
        expect_res("redxor_both", 1, 0);
        txn(6, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_res("and", 2, 2);

        // arithmetic
        txn(7, 7, 2, 1, 0, 0, 0, 0, 0, 0);
        expect_res("add_cin", 15, 14);
        txn(7, 6, 3, 0, 0, 0, 0, 0, 0, 0);
        expect_res("mult", 42, 42);

        // shift/rotate on the out register
        txn(0, 0, 4, 0, 1, 1, 0, 0, 0, 0);
        expect_res("shift_left", 21, 21);
        txn(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        expect_res("rot_right", 42, 42);
        txn(0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
        expect_res("rot_left", 21, 21);

        // illegal opcode and blink
        txn(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        expect_res("illegal6", 0, 0);
        chk("illegal6_inv0", inv_d[0], 1);
        chk("illegal6_inv1", inv_d[1], 1);
        chk("illegal6_leds0", leds_d[0], 16'hFFFF);
        chk("illegal6_leds1", leds_d[1], 16'h0000);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk($sformatf("blink0_s%0d", j + 2), leds_d[0], exp_l0[j]);
            chk($sformatf("blink1_s%0d", j + 2), leds_d[1], exp_l1[j]);
        end

        // reduction with arithmetic opcode is illegal; blinking continues (9 steps)
        txn(3, 3, 2, 0, 0, 0, 1, 0, 0, 0);
        expect_res("illegal_red", 0, 0);
        chk("illegal_red_inv0", inv_d[0], 1);
        chk("illegal_red_leds0", leds_d[0], 16'hFFFF);
        chk("illegal_red_leds1", leds_d[1], 16'hFFFF);

        // legal transaction clears the error
        txn(6, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_res("recover", 2, 2);
        chk("recover_inv0", inv_d[0], 0);
        chk("recover_inv1", inv_d[1], 0);
        chk("recover_leds0", leds_d[0], 16'h0000);
        chk("recover_leds1", leds_d[1], 16'h0000);

        // reset mid-blink
        txn(2, 2, 7, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("midrst_out", out_d[i], 0);
            chk("midrst_valid", ov_d[i], 0);
            chk("midrst_invalid", inv_d[i], 0);
            chk("midrst_leds", leds_d[i], 16'h0000);
        end
        rst = 1'b1;

        // back-to-back shifts/rotates then a mixed random burst, model-checked
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive(0, 0, 4 + (k % 2), 0, k[0] ^ k[1], k[2], 0, 0, 0, 0);
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            drive($urandom, $urandom, $urandom_range(0, 7), $urandom, $urandom, $urandom,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
